// File: rtl/div_quick_pkg.sv
// Shared types for the CLZ-accelerated signed/unsigned divider: FSM states,
// the registered result record and the final sign fixup.
package div_quick_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int DIV_WIDTH_DEF = 32;
    localparam int CLZ_W         = $clog2(DIV_WIDTH_DEF);

    // Result fields are sized for the widest supported configuration; the top
    // zero-extends into them and slices its own width back out.
    localparam int MAX_W    = 64;
    localparam int MAX_ID_W = 8;

    typedef struct packed {
        logic [MAX_W-1:0]    quotient;
        logic [MAX_W-1:0]    remainder;
        logic [MAX_ID_W-1:0] id;
        logic                div_by_zero;
    } result_t;

    // Negation at MAX_W truncates to the same two's-complement value at any
    // narrower width, so |MIN| / 1 comes back out as MIN.
    function automatic result_t sign_fixup(input logic [MAX_W-1:0]    q,
                                           input logic [MAX_W-1:0]    r,
                                           input logic                neg_q,
                                           input logic                neg_r,
                                           input logic [MAX_ID_W-1:0] id);
        result_t res;
        res.quotient    = neg_q ? -q : q;
        res.remainder   = neg_r ? -r : r;
        res.id          = id;
        res.div_by_zero = 1'b0;
        return res;
    endfunction

endpackage

// File: rtl/clz.sv
// Count leading zeros. The count for an all-zero input is unspecified.
module clz #(
    parameter int W = 32
) (
    input  logic [W-1:0]         value,
    output logic [$clog2(W)-1:0] count
);
    localparam int CW = $clog2(W);

    // Scanning upward lets the highest set bit have the final say.
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            if (value[i]) count = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/div_quick_clz_signed.sv
// Handshaked iterative divider; each RUN step aligns the normalised divisor
// with the remainder's leading one and retires one quotient bit.
module div_quick_clz_signed
    import div_quick_pkg::*;
#(
    parameter int DIV_WIDTH = 32,
    parameter int ID_W      = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 in_ready,
    input  logic                 is_signed,
    input  logic [ID_W-1:0]      id_in,
    input  logic [DIV_WIDTH-1:0] dividend,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DIV_WIDTH-1:0] quotient,
    output logic [DIV_WIDTH-1:0] remainder,
    output logic [ID_W-1:0]      id_out,
    output logic                 div_by_zero
);
    localparam int CW = $clog2(DIV_WIDTH);

    state_t               state_q, state_d;
    result_t              res_q, res_d;
    logic [DIV_WIDTH-1:0] rem_q, rem_d, quo_q, quo_d;
    logic [DIV_WIDTH-1:0] ndiv_q, ndiv_d, adiv_q, adiv_d;
    logic [CW-1:0]        clzd_q, clzd_d;
    logic                 negq_q, negq_d, negr_q, negr_d;
    logic [ID_W-1:0]      id_q, id_d;

    logic                 a_neg, b_neg, accept;
    logic [DIV_WIDTH-1:0] a_abs, b_abs, t1, t;
    logic [CW-1:0]        clz_b, clz_r, qidx;
    logic                 borrow, terminate;
    logic                 unused_hi;

    assign a_neg  = is_signed & dividend[DIV_WIDTH-1];
    assign b_neg  = is_signed & divisor[DIV_WIDTH-1];
    assign a_abs  = a_neg ? -dividend : dividend;
    assign b_abs  = b_neg ? -divisor : divisor;
    assign accept = start & in_ready & ~abort;

    clz #(.W(DIV_WIDTH)) u_clz_div (.value(b_abs), .count(clz_b));
    clz #(.W(DIV_WIDTH)) u_clz_rem (.value(rem_q), .count(clz_r));

    // One alignment step; the borrow path backs off by one bit position.
    always_comb begin
        terminate = rem_q < adiv_q;
        t1        = ndiv_q >> clz_r;
        borrow    = rem_q < t1;
        t         = borrow ? (t1 >> 1) : t1;
        qidx      = clzd_q - clz_r - CW'(borrow);
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        ndiv_d  = ndiv_q;
        adiv_d  = adiv_q;
        clzd_d  = clzd_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    id_d   = id_in;
                    negq_d = a_neg ^ b_neg;
                    negr_d = a_neg;
                    rem_d  = a_abs;
                    quo_d  = '0;
                    adiv_d = b_abs;
                    ndiv_d = b_abs << clz_b;
                    clzd_d = clz_b;
                    if (divisor == '0) begin
                        state_d           = DONE;
                        res_d.quotient    = MAX_W'({DIV_WIDTH{1'b1}});
                        res_d.remainder   = MAX_W'(dividend);
                        res_d.id          = MAX_ID_W'(id_in);
                        res_d.div_by_zero = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (terminate) begin
                    res_d   = sign_fixup(MAX_W'(quo_q), MAX_W'(rem_q), negq_q,
                                         negr_q, MAX_ID_W'(id_q));
                    state_d = DONE;
                end else begin
                    rem_d = rem_q - t;
                    quo_d = quo_q | (DIV_WIDTH'(1) << qidx);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
        end
    end

    // Working registers are only meaningful after an accept.
    always_ff @(posedge clk) begin
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        ndiv_q <= ndiv_d;
        adiv_q <= adiv_d;
        clzd_q <= clzd_d;
        negq_q <= negq_d;
        negr_q <= negr_d;
        id_q   <= id_d;
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = res_q.quotient[DIV_WIDTH-1:0];
    assign remainder   = res_q.remainder[DIV_WIDTH-1:0];
    assign id_out      = res_q.id[ID_W-1:0];
    assign div_by_zero = res_q.div_by_zero;
    assign unused_hi   = ^{res_q.quotient >> DIV_WIDTH, res_q.remainder >> DIV_WIDTH,
                           res_q.id >> ID_W};

endmodule
